oam_buffer: RTL and testbench

Double-buffered object attribute memory feeding the sprite object engine. Game logic writes sprite entries into a back bank through a valid/ready port. A commit request copies the whole back bank into the front bank atomically at the start of vertical blanking, so the object engine never sees a half-updated frame. The object engine reads the front bank through its free-running `oam_addr`/`oam_data` port.

---
 rtl/oam_buffer.sv | 104 ++++++++++
 tb/tb_oam_buffer.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_buffer.sv
// Double-buffered sprite attribute memory: game logic fills the back bank,
// the object engine reads the front bank, and a commit copies back to front at vblank.
module oam_buffer #(
  parameter int OAM_WIDTH   = 32,
  parameter int OAM_DEPTH   = 8,
  parameter int V_SWAP_LINE = 480
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [9:0]           y,
  input  logic [2:0]           oam_addr,
  output logic [OAM_WIDTH-1:0] oam_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [2:0]           wr_addr,
  input  logic [OAM_WIDTH-1:0] wr_data,
  input  logic                 clear_req,
  input  logic                 commit_req,
  output logic                 commit_pending,
  output logic                 frame_tick,
  output logic [7:0]           swap_count
);

  localparam logic [9:0] SWAP_Y = 10'(V_SWAP_LINE);
  localparam int         EN_BIT = OAM_WIDTH - 1;

  logic [OAM_WIDTH-1:0] front_q [OAM_DEPTH];
  logic [OAM_WIDTH-1:0] front_d [OAM_DEPTH];
  logic [OAM_WIDTH-1:0] back_q  [OAM_DEPTH];
  logic [OAM_WIDTH-1:0] back_d  [OAM_DEPTH];

  logic       commit_pending_q, commit_pending_d;
  logic       frame_tick_q, frame_tick_d;
  logic [7:0] swap_count_q, swap_count_d;
  logic       y_match_q, y_match_d;

  logic y_hit;
  logic vb_start;
  logic wr_fire;
  logic swap;

  always_comb begin
    y_hit    = (y == SWAP_Y);
    vb_start = y_hit & ~y_match_q;
    // Blocking writes on vb_start keeps the copy a clean snapshot.
    wr_ready = rst_n & ~vb_start;
    wr_fire  = wr_valid & wr_ready;
    swap     = vb_start & (commit_pending_q | commit_req);
  end

  always_comb begin
    back_d = back_q;
    if (clear_req) begin
      for (int i = 0; i < OAM_DEPTH; i++) begin
        back_d[i][EN_BIT] = 1'b0;
      end
    end
    if (wr_fire) begin
      back_d[wr_addr] = wr_data;
    end
  end

  always_comb begin
    front_d = front_q;
    if (swap) begin
      front_d = back_q;
    end
  end

  always_comb begin
    commit_pending_d = swap ? 1'b0 : (commit_pending_q | commit_req);
    frame_tick_d     = swap;
    swap_count_d     = swap_count_q + {7'd0, swap};
    y_match_d        = y_hit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < OAM_DEPTH; i++) begin
        front_q[i] <= '0;
        back_q[i]  <= '0;
      end
      commit_pending_q <= 1'b0;
      frame_tick_q     <= 1'b0;
      swap_count_q     <= 8'd0;
      y_match_q        <= 1'b0;
    end else begin
      for (int i = 0; i < OAM_DEPTH; i++) begin
        front_q[i] <= front_d[i];
        back_q[i]  <= back_d[i];
      end
      commit_pending_q <= commit_pending_d;
      frame_tick_q     <= frame_tick_d;
      swap_count_q     <= swap_count_d;
      y_match_q        <= y_match_d;
    end
  end

  assign oam_data       = front_q[oam_addr];
  assign commit_pending = commit_pending_q;
  assign frame_tick     = frame_tick_q;
  assign swap_count     = swap_count_q;

endmodule

// File: tb/tb_oam_buffer.sv
// Directed bench for oam_buffer: reset, commit/swap timing, collisions,
// clear-vs-write priority and swap counter wrap.
module tb_oam_buffer;

  logic        clk;
  logic        rst_n;
  logic [9:0]  y;
  logic [2:0]  oam_addr;
  logic [31:0] oam_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic        clear_req;
  logic        commit_req;
  logic        commit_pending;
  logic        frame_tick;
  logic [7:0]  swap_count;

  int checks;
  int errors;
  int exp_swaps;

  oam_buffer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .y              (y),
    .oam_addr       (oam_addr),
    .oam_data       (oam_data),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .clear_req      (clear_req),
    .commit_req     (commit_req),
    .commit_pending (commit_pending),
    .frame_tick     (frame_tick),
    .swap_count     (swap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after a rising edge; outputs are sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [2:0] a, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    tick(1);
    wr_valid = 1'b0;
  endtask

  task automatic vblank(input bit commit);
    if (commit) begin
      commit_req = 1'b1;
      tick(1);
      commit_req = 1'b0;
    end
    y = 10'd480;
    tick(4);
    y = 10'd100;
    tick(2);
  endtask

  task automatic test_reset;
    rst_n      = 1'b0;
    y          = 10'd100;
    oam_addr   = 3'd0;
    wr_valid   = 1'b0;
    wr_addr    = 3'd0;
    wr_data    = '0;
    clear_req  = 1'b0;
    commit_req = 1'b0;
    tick(3);
    for (int i = 0; i < 8; i++) begin
      oam_addr = 3'(i);
      #1;
      checks++;
      if (oam_data !== 32'h0) begin
        $display("FAIL reset_oam_data[%0d] got %h want %h", i, oam_data, 32'h0);
        errors++;
      end
    end
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b0) begin
      $display("FAIL reset_wr_ready got %b want 0", wr_ready);
      errors++;
    end
    checks++;
    if (swap_count !== 8'd0 || commit_pending !== 1'b0 || frame_tick !== 1'b0) begin
      $display("FAIL reset_state got cnt=%0d pend=%b tick=%b want 0 0 0",
               swap_count, commit_pending, frame_tick);
      errors++;
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin
      $display("FAIL release_wr_ready got %b want 1", wr_ready);
      errors++;
    end
    tick(1);
  endtask

  task automatic test_basic_commit;
    int ticks;
    write(3'd2, 32'h8001_4050);
    commit_req = 1'b1;
    tick(1);
    commit_req = 1'b0;
    oam_addr = 3'd2;
    @(negedge clk);
    checks++;
    if (oam_data !== 32'h0) begin
      $display("FAIL basic_front_early got %h want %h", oam_data, 32'h0);
      errors++;
    end
    checks++;
    if (commit_pending !== 1'b1) begin
      $display("FAIL basic_pending got %b want 1", commit_pending);
      errors++;
    end
    @(posedge clk);
    #1;
    y = 10'd480;
    ticks = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) ticks++;
    end
    checks++;
    if (ticks != 1) begin
      $display("FAIL basic_frame_tick_cycles got %0d want 1", ticks);
      errors++;
    end
    checks++;
    if (oam_data !== 32'h8001_4050) begin
      $display("FAIL basic_front2 got %h want %h", oam_data, 32'h8001_4050);
      errors++;
    end
    exp_swaps = 1;
    checks++;
    if (swap_count !== 8'(exp_swaps) || commit_pending !== 1'b0) begin
      $display("FAIL basic_count got cnt=%0d pend=%b want %0d 0",
               swap_count, commit_pending, exp_swaps);
      errors++;
    end
    @(posedge clk);
    #1;
    y = 10'd100;
    tick(2);
  endtask

  task automatic test_no_commit;
    int ticks;
    write(3'd0, 32'h8000_1234);
    y = 10'd480;
    ticks = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) ticks++;
    end
    @(posedge clk);
    #1;
    y = 10'd100;
    tick(2);
    checks++;
    if (ticks != 0) begin
      $display("FAIL nocommit_frame_tick got %0d want 0", ticks);
      errors++;
    end
    checks++;
    if (swap_count !== 8'(exp_swaps)) begin
      $display("FAIL nocommit_count got %0d want %0d", swap_count, exp_swaps);
      errors++;
    end
    oam_addr = 3'd0;
    #1;
    checks++;
    if (oam_data !== 32'h0) begin
      $display("FAIL nocommit_front0 got %h want %h", oam_data, 32'h0);
      errors++;
    end
    oam_addr = 3'd2;
    #1;
    checks++;
    if (oam_data !== 32'h8001_4050) begin
      $display("FAIL nocommit_front2 got %h want %h", oam_data, 32'h8001_4050);
      errors++;
    end
  endtask

  task automatic test_multi_commit;
    int ticks;
    for (int i = 0; i < 3; i++) begin
      commit_req = 1'b1;
      tick(1);
      commit_req = 1'b0;
      tick(1);
    end
    y = 10'd480;
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) ticks++;
    end
    @(posedge clk);
    #1;
    y = 10'd100;
    tick(2);
    exp_swaps++;
    checks++;
    if (ticks != 1 || swap_count !== 8'(exp_swaps)) begin
      $display("FAIL multi_commit got ticks=%0d cnt=%0d want 1 %0d",
               ticks, swap_count, exp_swaps);
      errors++;
    end
    oam_addr = 3'd0;
    #1;
    checks++;
    if (oam_data !== 32'h8000_1234) begin
      $display("FAIL multi_front0 got %h want %h", oam_data, 32'h8000_1234);
      errors++;
    end
  endtask

  task automatic test_collision;
    y          = 10'd480;
    commit_req = 1'b1;
    wr_valid   = 1'b1;
    wr_addr    = 3'd3;
    wr_data    = 32'h8123_4567;
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b0) begin
      $display("FAIL coll_wr_ready got %b want 0", wr_ready);
      errors++;
    end
    tick(1);
    commit_req = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b1 || frame_tick !== 1'b1 || commit_pending !== 1'b0) begin
      $display("FAIL coll_after got rdy=%b tick=%b pend=%b want 1 1 0",
               wr_ready, frame_tick, commit_pending);
      errors++;
    end
    tick(1);
    wr_valid = 1'b0;
    exp_swaps++;
    oam_addr = 3'd3;
    @(negedge clk);
    checks++;
    if (oam_data !== 32'h0 || swap_count !== 8'(exp_swaps)) begin
      $display("FAIL coll_front3 got %h cnt=%0d want %h %0d",
               oam_data, swap_count, 32'h0, exp_swaps);
      errors++;
    end
    @(posedge clk);
    #1;
    y = 10'd100;
    tick(2);
    vblank(1);
    exp_swaps++;
    checks++;
    if (oam_data !== 32'h8123_4567) begin
      $display("FAIL coll_held_write got %h want %h", oam_data, 32'h8123_4567);
      errors++;
    end
  endtask

  task automatic test_clear_vs_write;
    logic [31:0] exp;
    for (int i = 0; i < 8; i++) begin
      write(3'(i), 32'h8000_0100 + 32'(i));
    end
    clear_req = 1'b1;
    wr_valid  = 1'b1;
    wr_addr   = 3'd5;
    wr_data   = 32'h8000_0000;
    tick(1);
    clear_req = 1'b0;
    wr_valid  = 1'b0;
    vblank(1);
    exp_swaps++;
    for (int i = 0; i < 8; i++) begin
      exp = (i == 5) ? 32'h8000_0000 : 32'h0000_0100 + 32'(i);
      oam_addr = 3'(i);
      #1;
      checks++;
      if (oam_data !== exp) begin
        $display("FAIL clear_front[%0d] got %h want %h", i, oam_data, exp);
        errors++;
      end
    end
  endtask

  task automatic test_clear_on_swap;
    write(3'd1, 32'h8000_0011);
    y          = 10'd480;
    commit_req = 1'b1;
    clear_req  = 1'b1;
    tick(1);
    commit_req = 1'b0;
    clear_req  = 1'b0;
    tick(2);
    y = 10'd100;
    tick(2);
    exp_swaps++;
    oam_addr = 3'd1;
    #1;
    checks++;
    if (oam_data !== 32'h8000_0011) begin
      $display("FAIL clrswap_front1 got %h want %h", oam_data, 32'h8000_0011);
      errors++;
    end
    vblank(1);
    exp_swaps++;
    checks++;
    if (oam_data !== 32'h0000_0011) begin
      $display("FAIL clrswap_after got %h want %h", oam_data, 32'h0000_0011);
      errors++;
    end
  endtask

  task automatic test_wrap;
    int n;
    checks++;
    if (swap_count !== 8'(exp_swaps)) begin
      $display("FAIL wrap_start got %0d want %0d", swap_count, exp_swaps);
      errors++;
    end
    n = 256 - exp_swaps;
    for (int i = 0; i < n - 1; i++) begin
      vblank(1);
    end
    checks++;
    if (swap_count !== 8'd255) begin
      $display("FAIL wrap_255 got %0d want 255", swap_count);
      errors++;
    end
    vblank(1);
    checks++;
    if (swap_count !== 8'd0) begin
      $display("FAIL wrap_zero got %0d want 0", swap_count);
      errors++;
    end
    exp_swaps = 0;
  endtask

  task automatic test_reset_mid_commit;
    commit_req = 1'b1;
    tick(1);
    commit_req = 1'b0;
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    oam_addr = 3'd1;
    @(negedge clk);
    checks++;
    if (commit_pending !== 1'b0 || oam_data !== 32'h0) begin
      $display("FAIL midrst got pend=%b data=%h want 0 %h",
               commit_pending, oam_data, 32'h0);
      errors++;
    end
    @(posedge clk);
    #1;
    vblank(0);
    checks++;
    if (swap_count !== 8'd0 || oam_data !== 32'h0) begin
      $display("FAIL midrst_noswap got cnt=%0d data=%h want 0 %h",
               swap_count, oam_data, 32'h0);
      errors++;
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_swaps = 0;
    test_reset();
    test_basic_commit();
    test_no_commit();
    test_multi_commit();
    test_collision();
    test_clear_vs_write();
    test_clear_on_swap();
    test_wrap();
    test_reset_mid_commit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
